// File: rtl/vga_sync_monitor_if.sv
// Sync/video inputs and qualification results of the VGA timing monitor.
interface vga_sync_monitor_if;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic        locked;
    logic        timing_err;
    logic        frame_done;
    logic [9:0]  meas_h_total;
    logic [9:0]  meas_h_sync;
    logic [9:0]  meas_h_active;
    logic [9:0]  meas_v_total;
    logic [9:0]  meas_v_sync;
    logic [9:0]  meas_v_active;
    logic [15:0] err_cnt;
    logic [15:0] frame_cnt;

    modport master (
        output hsync, vsync, valid,
        input  locked, timing_err, frame_done,
        input  meas_h_total, meas_h_sync, meas_h_active,
        input  meas_v_total, meas_v_sync, meas_v_active,
        input  err_cnt, frame_cnt
    );

    modport slave (
        input  hsync, vsync, valid,
        output locked, timing_err, frame_done,
        output meas_h_total, meas_h_sync, meas_h_active,
        output meas_v_total, meas_v_sync, meas_v_active,
        output err_cnt, frame_cnt
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// VGA sync timing monitor: measures line/frame intervals, qualifies frames, locks.
// Define VGA_MON_STATS_EN to build the frame/error statistics counters.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input logic               i_pclk,
    input logic               i_reset,
    vga_sync_monitor_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [9:0] MAX        = 10'd1023;
    localparam logic [9:0] L_H_TOTAL  = 10'(H_TOTAL);
    localparam logic [9:0] L_H_SYNC   = 10'(H_SYNC);
    localparam logic [9:0] L_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] L_V_TOTAL  = 10'(V_TOTAL);
    localparam logic [9:0] L_V_SYNC   = 10'(V_SYNC);
    localparam logic [9:0] L_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [3:0] L_LOCK     = 4'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == MAX) ? v : v + 10'd1;
    endfunction

    logic       r_hs_prev, r_vs_prev, r_de_prev;
    logic [9:0] r_h_run, r_hs_low, r_de_run;
    logic [9:0] r_v_run, r_vs_lines, r_act_lines;
    logic       r_frame_bad;
    logic [9:0] r_meas_h_total, r_meas_h_sync, r_meas_h_active;
    logic [9:0] r_meas_v_total, r_meas_v_sync, r_meas_v_active;
    state_t     r_state;
    logic [3:0] r_good_cnt;
    logic       r_locked, r_timing_err, r_frame_done;

    logic       w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_de_fall, w_de_rise;
    logic [9:0] w_h_next, w_v_eff;
    logic       w_line_bad, w_good, w_timeout;

    assign w_hs_fall = r_hs_prev & ~bus.hsync;
    assign w_hs_rise = ~r_hs_prev & bus.hsync;
    assign w_vs_fall = r_vs_prev & ~bus.vsync;
    assign w_vs_rise = ~r_vs_prev & bus.vsync;
    assign w_de_fall = r_de_prev & ~bus.valid;
    assign w_de_rise = ~r_de_prev & bus.valid;

    assign w_h_next = w_hs_fall ? 10'd1 : sat_inc(r_h_run);
    // A line ending on the frame boundary edge belongs to the frame being closed
    assign w_v_eff  = w_hs_fall ? sat_inc(r_v_run) : r_v_run;

    assign w_line_bad = (w_hs_fall && (r_h_run != L_H_TOTAL))
                      | (w_hs_rise && (r_hs_low != L_H_SYNC))
                      | (w_de_fall && (r_de_run != L_H_ACTIVE));

    assign w_good = !(r_frame_bad | w_line_bad)
                  && (w_v_eff == L_V_TOTAL)
                  && (r_meas_v_sync == L_V_SYNC)
                  && (r_act_lines == L_V_ACTIVE);

    assign w_timeout = (r_state != SEARCH)
                     && ((w_h_next == MAX) || (w_v_eff == MAX));

    always_ff @(posedge i_pclk or posedge i_reset) begin
        if (i_reset) begin
            r_hs_prev       <= 1'b1;
            r_vs_prev       <= 1'b1;
            r_de_prev       <= 1'b0;
            r_h_run         <= '0;
            r_hs_low        <= '0;
            r_de_run        <= '0;
            r_v_run         <= '0;
            r_vs_lines      <= '0;
            r_act_lines     <= '0;
            r_frame_bad     <= 1'b0;
            r_meas_h_total  <= '0;
            r_meas_h_sync   <= '0;
            r_meas_h_active <= '0;
            r_meas_v_total  <= '0;
            r_meas_v_sync   <= '0;
            r_meas_v_active <= '0;
        end else begin
            r_hs_prev <= bus.hsync;
            r_vs_prev <= bus.vsync;
            r_de_prev <= bus.valid;
            r_h_run   <= w_h_next;
            if (w_hs_fall) r_meas_h_total <= r_h_run;

            r_hs_low <= bus.hsync ? 10'd0 : (w_hs_fall ? 10'd1 : sat_inc(r_hs_low));
            if (w_hs_rise) r_meas_h_sync <= r_hs_low;

            r_de_run <= !bus.valid ? 10'd0 : (w_de_rise ? 10'd1 : sat_inc(r_de_run));
            if (w_de_fall) r_meas_h_active <= r_de_run;

            if (bus.vsync)      r_vs_lines <= '0;
            else if (w_vs_fall) r_vs_lines <= w_hs_fall ? 10'd1 : 10'd0;
            else if (w_hs_fall) r_vs_lines <= sat_inc(r_vs_lines);
            if (w_vs_rise) r_meas_v_sync <= r_vs_lines;

            if (w_vs_fall) begin
                r_meas_v_total  <= w_v_eff;
                r_meas_v_active <= r_act_lines;
                r_v_run         <= '0;
                r_act_lines     <= '0;
                r_frame_bad     <= 1'b0;
            end else begin
                r_v_run     <= w_v_eff;
                r_frame_bad <= r_frame_bad | w_line_bad;
                if (w_de_rise) r_act_lines <= sat_inc(r_act_lines);
            end
        end
    end

    always_ff @(posedge i_pclk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= SEARCH;
            r_good_cnt   <= '0;
            r_locked     <= 1'b0;
            r_timing_err <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_timing_err <= 1'b0;
            if (w_timeout) begin
                r_state      <= SEARCH;
                r_good_cnt   <= '0;
                r_locked     <= 1'b0;
                r_timing_err <= 1'b1;
            end else if (w_vs_fall) begin
                unique case (r_state)
                    SEARCH: begin
                        r_state    <= TRACK;
                        r_good_cnt <= '0;
                    end
                    TRACK, LOCKED: begin
                        r_frame_done <= 1'b1;
                        if (!w_good) begin
                            r_state      <= TRACK;
                            r_good_cnt   <= '0;
                            r_locked     <= 1'b0;
                            r_timing_err <= 1'b1;
                        end else if (r_state == TRACK) begin
                            r_good_cnt <= r_good_cnt + 4'd1;
                            if (r_good_cnt + 4'd1 == L_LOCK) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

`ifdef VGA_MON_STATS_EN
    logic [15:0] r_frame_cnt, r_err_cnt;

    always_ff @(posedge i_pclk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_timing_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_cnt   = r_err_cnt;
`else
    assign bus.frame_cnt = '0;
    assign bus.err_cnt   = '0;
`endif

    assign bus.locked        = r_locked;
    assign bus.timing_err    = r_timing_err;
    assign bus.frame_done    = r_frame_done;
    assign bus.meas_h_total  = r_meas_h_total;
    assign bus.meas_h_sync   = r_meas_h_sync;
    assign bus.meas_h_active = r_meas_h_active;
    assign bus.meas_v_total  = r_meas_v_total;
    assign bus.meas_v_sync   = r_meas_v_sync;
    assign bus.meas_v_active = r_meas_v_active;
endmodule
